// File: rtl/perf_pkg.sv
`default_nettype none
// ============================================================================
// perf_pkg : shared encodings for the pipeline performance monitor
// Revision : 1.0
// ============================================================================
package perf_pkg;

  localparam int DEFAULT_CNT_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Counter slots, also the bit order of the overflow flags
  localparam int IDX_CYCLE  = 0;
  localparam int IDX_STALL  = 1;
  localparam int IDX_FLUSH  = 2;
  localparam int IDX_RETIRE = 3;
  localparam int NUM_CNT    = 4;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// sat_counter : saturating up-counter with enable, clear and saturated flag
// Revision    : 1.0   (sat port present only with PERF_OVF_FLAG_EN)
// ============================================================================
module sat_counter
  import perf_pkg::*;
#(
  parameter int W = DEFAULT_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
`ifdef PERF_OVF_FLAG_EN
  ,
  output logic         sat
`endif
);

  localparam logic [W-1:0] MAX = '1;

  logic at_max;
  assign at_max = (count == MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                count <= '0;
    else if (clr)           count <= '0;
    else if (en && !at_max) count <= count + 1'b1;
  end

`ifdef PERF_OVF_FLAG_EN
  localparam logic [W-1:0] NEAR_MAX = {{(W-1){1'b1}}, 1'b0};

  // Set on the edge that moves the count onto MAX, so it rises with it
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            sat <= 1'b0;
    else if (clr)                       sat <= 1'b0;
    else if (en && count == NEAR_MAX)   sat <= 1'b1;
  end
`endif

endmodule
`default_nettype wire

// File: rtl/pipe_perf_counter.sv
`default_nettype none
// ============================================================================
// pipe_perf_counter : cycle/stall/flush/retire monitor with snapshot handshake
// Revision          : 1.0   (optional ovf_o via PERF_OVF_FLAG_EN)
// ============================================================================
module pipe_perf_counter
  import perf_pkg::*;
#(
  parameter int CNT_W       = DEFAULT_CNT_W,
  parameter int CYCLE_LIMIT = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             branch_i,
  input  logic             flush_i,
  input  logic             retire_i,
  input  logic             clr_i,
  input  logic             snap_req_i,
  input  logic             snap_ready_i,
  output logic             snap_valid_o,
  output logic [CNT_W-1:0] snap_cycle_o,
  output logic [CNT_W-1:0] snap_stall_o,
  output logic [CNT_W-1:0] snap_flush_o,
  output logic [CNT_W-1:0] snap_retire_o,
  output logic [1:0]       state_o,
  output logic             done_o
`ifdef PERF_OVF_FLAG_EN
  ,
  output logic [NUM_CNT-1:0] ovf_o
`endif
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(CYCLE_LIMIT);

  state_t             state_q, state_d;
  logic               counting;
  logic [NUM_CNT-1:0] inc;
  logic [CNT_W-1:0]   cnt [NUM_CNT];

  assign counting          = (state_q == ST_RUN) && start_i;
  assign inc[IDX_CYCLE]    = counting;
  assign inc[IDX_STALL]    = counting && stall_i && !branch_i;
  assign inc[IDX_FLUSH]    = counting && flush_i;
  assign inc[IDX_RETIRE]   = counting && retire_i;

  generate
    for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
      sat_counter #(.W(CNT_W)) u_cnt (
        .clk   (clk_i),
        .rst   (rst_i),
        .clr   (clr_i),
        .en    (inc[i]),
        .count (cnt[i])
`ifdef PERF_OVF_FLAG_EN
        ,
        .sat   (ovf_o[i])
`endif
      );
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_i) state_d = ST_RUN;
      ST_RUN: begin
        if (!start_i)
          state_d = ST_IDLE;
        else if (CYCLE_LIMIT != 0 && (cnt[IDX_CYCLE] + 1'b1) == LIMIT)
          state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
    if (clr_i) state_d = ST_IDLE;
  end

  assign state_o = state_q;
  assign done_o  = (state_q == ST_DONE);

  // Captures pre-increment register values; requests during valid are dropped
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      snap_valid_o  <= 1'b0;
      snap_cycle_o  <= '0;
      snap_stall_o  <= '0;
      snap_flush_o  <= '0;
      snap_retire_o <= '0;
    end else if (snap_valid_o) begin
      if (snap_ready_i) snap_valid_o <= 1'b0;
    end else if (snap_req_i) begin
      snap_valid_o  <= 1'b1;
      snap_cycle_o  <= cnt[IDX_CYCLE];
      snap_stall_o  <= cnt[IDX_STALL];
      snap_flush_o  <= cnt[IDX_FLUSH];
      snap_retire_o <= cnt[IDX_RETIRE];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_perf_counter.sv
`default_nettype none
// ============================================================================
// tb_pipe_perf_counter : directed bench for pipe_perf_counter (32-bit and 4-bit)
// Revision             : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_pipe_perf_counter;

  logic clk = 1'b0;
  logic rst, start, stall, branch, flush, retire, clr, snap_req, snap_ready;

  logic        snap_valid;
  logic [31:0] s_cycle, s_stall, s_flush, s_retire;
  logic [1:0]  state;
  logic        done;

  logic        v4;
  logic [3:0]  c4, st4, f4, r4;
  logic [1:0]  state4;
  logic        done4;
`ifdef PERF_OVF_FLAG_EN
  logic [3:0]  ovf, ovf4;
`endif

  logic [31:0] rc, rs, rf, rr;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_perf_counter #(.CNT_W(32), .CYCLE_LIMIT(64)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall), .branch_i(branch),
    .flush_i(flush), .retire_i(retire), .clr_i(clr), .snap_req_i(snap_req),
    .snap_ready_i(snap_ready), .snap_valid_o(snap_valid), .snap_cycle_o(s_cycle),
    .snap_stall_o(s_stall), .snap_flush_o(s_flush), .snap_retire_o(s_retire),
    .state_o(state), .done_o(done)
`ifdef PERF_OVF_FLAG_EN
    , .ovf_o(ovf)
`endif
  );

  pipe_perf_counter #(.CNT_W(4), .CYCLE_LIMIT(0)) dut4 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall), .branch_i(branch),
    .flush_i(flush), .retire_i(retire), .clr_i(clr), .snap_req_i(snap_req),
    .snap_ready_i(snap_ready), .snap_valid_o(v4), .snap_cycle_o(c4),
    .snap_stall_o(st4), .snap_flush_o(f4), .snap_retire_o(r4),
    .state_o(state4), .done_o(done4)
`ifdef PERF_OVF_FLAG_EN
    , .ovf_o(ovf4)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap_read();
    snap_req = 1'b1;
    tick();
    snap_req   = 1'b0;
    rc = s_cycle; rs = s_stall; rf = s_flush; rr = s_retire;
    snap_ready = 1'b1;
    tick();
    snap_ready = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; stall = 0; branch = 0; flush = 0; retire = 0;
    clr = 0; snap_req = 0; snap_ready = 0;
    repeat (2) tick();
    total++; if (state !== 2'b00) begin bad++; $display("FAIL reset_state got=%0d exp=0", state); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0d exp=0", done); end
    total++; if (snap_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0d exp=0", snap_valid); end
    total++; if (s_cycle !== 32'd0 || s_retire !== 32'd0) begin bad++;
      $display("FAIL reset_fields got cyc=%0d ret=%0d exp=0", s_cycle, s_retire); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_cycle_count();
    start = 1'b1;
    tick();
    repeat (10) tick();
    total++; if (state !== 2'b01) begin bad++; $display("FAIL run_state got=%0d exp=1", state); end
    start = 1'b0;
    tick();
    total++; if (state !== 2'b00) begin bad++; $display("FAIL stop_state got=%0d exp=0", state); end
    snap_read();
    total++; if (rc !== 32'd10) begin bad++; $display("FAIL cyc10 got=%0d exp=10", rc); end
    total++; if (rs !== 0 || rf !== 0 || rr !== 0) begin bad++;
      $display("FAIL idle_events got s=%0d f=%0d r=%0d exp=0", rs, rf, rr); end
  endtask

  task automatic test_events();
    do_clr();
    start = 1'b1;
    tick();
    stall = 1; flush = 1;             tick();
    branch = 1;                       tick();
    branch = 0; flush = 0; retire = 1; tick();
    stall = 0; retire = 0; start = 0; tick();
    snap_read();
    total++; if (rs !== 32'd2) begin bad++; $display("FAIL stall_cnt got=%0d exp=2", rs); end
    total++; if (rf !== 32'd2) begin bad++; $display("FAIL flush_cnt got=%0d exp=2", rf); end
    total++; if (rr !== 32'd1) begin bad++; $display("FAIL retire_cnt got=%0d exp=1", rr); end
    total++; if (rc !== 32'd3) begin bad++; $display("FAIL ev_cycle got=%0d exp=3", rc); end
  endtask

  task automatic test_limit();
    do_clr();
    start = 1'b1;
    tick();
    repeat (63) tick();
    total++; if (state !== 2'b01) begin bad++; $display("FAIL pre_limit_state got=%0d exp=1", state); end
    tick();
    total++; if (state !== 2'b10 || done !== 1'b1) begin bad++;
      $display("FAIL limit_done got st=%0d done=%0d exp st=2 done=1", state, done); end
    repeat (3) tick();
    start = 1'b0;
    tick();
    total++; if (state !== 2'b10) begin bad++; $display("FAIL done_sticky got=%0d exp=2", state); end
    snap_read();
    total++; if (rc !== 32'd64) begin bad++; $display("FAIL limit_cycle got=%0d exp=64", rc); end
    do_clr();
    total++; if (state !== 2'b00 || done !== 1'b0) begin bad++;
      $display("FAIL clr_state got st=%0d done=%0d exp 0 0", state, done); end
    snap_read();
    total++; if (rc !== 0 || rs !== 0 || rf !== 0 || rr !== 0) begin bad++;
      $display("FAIL clr_counts got c=%0d s=%0d f=%0d r=%0d exp=0", rc, rs, rf, rr); end
  endtask

  task automatic test_snapshot();
    do_clr();
    start = 1'b1;
    tick();
    repeat (20) tick();
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    total++; if (snap_valid !== 1'b1 || s_cycle !== 32'd20) begin bad++;
      $display("FAIL snap_capture got v=%0d cyc=%0d exp v=1 cyc=20", snap_valid, s_cycle); end
    for (int i = 0; i < 5; i++) begin
      snap_req = (i == 2);
      tick();
      total++; if (snap_valid !== 1'b1 || s_cycle !== 32'd20) begin bad++;
        $display("FAIL snap_hold[%0d] got v=%0d cyc=%0d exp v=1 cyc=20", i, snap_valid, s_cycle); end
    end
    snap_ready = 1'b1; snap_req = 1'b1;
    tick();
    total++; if (snap_valid !== 1'b0) begin bad++; $display("FAIL snap_accept got=%0d exp=0", snap_valid); end
    snap_ready = 1'b0; snap_req = 1'b0;
    tick();
    total++; if (snap_valid !== 1'b0) begin bad++; $display("FAIL accept_req_ignored got=%0d exp=0", snap_valid); end
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    total++; if (snap_valid !== 1'b1 || s_cycle !== 32'd28 || state !== 2'b00) begin bad++;
      $display("FAIL clr_keeps_snap got v=%0d cyc=%0d st=%0d exp v=1 cyc=28 st=0", snap_valid, s_cycle, state); end
    snap_ready = 1'b1;
    tick();
    snap_ready = 1'b0;
    start = 1'b0;
    tick();
  endtask

  task automatic test_saturation();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b1;
    tick();
    retire = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
`ifdef PERF_OVF_FLAG_EN
      if (k == 14) begin
        total++; if (ovf4[3] !== 1'b0) begin bad++; $display("FAIL ovf_early got=%0d exp=0", ovf4[3]); end
      end
      if (k == 15) begin
        total++; if (ovf4[3] !== 1'b1) begin bad++; $display("FAIL ovf_set got=%0d exp=1", ovf4[3]); end
      end
`endif
    end
`ifdef PERF_OVF_FLAG_EN
    total++; if (ovf4 !== 4'b1001) begin bad++; $display("FAIL ovf_vec got=%b exp=1001", ovf4); end
    total++; if (ovf !== 4'b0000) begin bad++; $display("FAIL ovf_wide got=%b exp=0000", ovf); end
`endif
    retire = 1'b0; start = 1'b0;
    tick();
    snap_read();
    total++; if (r4 !== 4'd15 || c4 !== 4'd15) begin bad++;
      $display("FAIL sat4 got r=%0d c=%0d exp 15 15", r4, c4); end
    total++; if (rr !== 32'd20) begin bad++; $display("FAIL retire32 got=%0d exp=20", rr); end
    total++; if (state4 !== 2'b00 || done4 !== 1'b0) begin bad++;
      $display("FAIL unlimited got st=%0d done=%0d exp 0 0", state4, done4); end
    do_clr();
`ifdef PERF_OVF_FLAG_EN
    total++; if (ovf4 !== 4'b0000) begin bad++; $display("FAIL ovf_clr got=%b exp=0000", ovf4); end
`endif
  endtask

  task automatic test_async_reset();
    start = 1'b1;
    tick();
    repeat (5) tick();
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    total++; if (snap_valid !== 1'b1 || s_cycle !== 32'd5) begin bad++;
      $display("FAIL pre_rst_snap got v=%0d cyc=%0d exp v=1 cyc=5", snap_valid, s_cycle); end
    #3;
    rst = 1'b1;
    #1;
    total++; if (state !== 2'b00 || snap_valid !== 1'b0 || s_cycle !== 32'd0 || done !== 1'b0) begin bad++;
      $display("FAIL async_rst got st=%0d v=%0d cyc=%0d done=%0d exp 0 0 0 0", state, snap_valid, s_cycle, done); end
    start = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_cycle_count();
    test_events();
    test_limit();
    test_snapshot();
    test_saturation();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/pipe_perf_counter.md
Name: pipe_perf_counter

Overview:
Hardware performance monitor that sits directly downstream of the 5-stage CPU pipeline and consumes its hazard, flush and writeback signals. It counts cycles, load-use stalls, flushes and retired instructions while the CPU is started. It stops automatically after a programmable cycle budget. Software or the bench can take an atomic snapshot of all counters through a valid/ready handshake.

Parameters:
CNT_W, 32, width of every counter and snapshot field
CYCLE_LIMIT, 64, cycle budget after which counting stops (0 = unlimited)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
start_i  in  1  CPU start; counting is enabled only while high
stall_i  in  1  hazard unit stall request
branch_i  in  1  control unit branch decode; a stall with branch_i high is not a load-use stall
flush_i  in  1  IF/ID flush (taken branch)
retire_i  in  1  MEM/WB RegWrite or valid store retiring this cycle
clr_i  in  1  synchronous clear of all counters, returns to IDLE
snap_req_i  in  1  request snapshot (level sampled on clk_i)
snap_ready_i  in  1  consumer accepts snapshot
snap_valid_o  out  1  snapshot fields valid
snap_cycle_o  out  CNT_W  captured cycle count
snap_stall_o  out  CNT_W  captured stall count
snap_flush_o  out  CNT_W  captured flush count
snap_retire_o  out  CNT_W  captured retired count
state_o  out  2  00 IDLE, 01 RUN, 10 DONE
done_o  out  1  high in DONE

Behaviour:
- Reset (async, rst_i=1): all counters 0, state IDLE, snap_valid_o 0, all snap_* 0, done_o 0.
- FSM transitions:
  - IDLE -> RUN when start_i=1.
  - RUN -> IDLE when start_i=0.
  - RUN -> DONE when the cycle counter's next value equals CYCLE_LIMIT and CYCLE_LIMIT != 0.
  - DONE exits only on clr_i or reset.
  - clr_i has priority over every transition and over all increments.
- Increments in RUN (all per-clock, all may fire simultaneously):
  - cycle +1 every cycle.
  - stall +1 if stall_i & ~branch_i.
  - flush +1 if flush_i.
  - retire +1 if retire_i.
- Counters are frozen in IDLE and DONE. In the cycle of the RUN->DONE transition, that cycle's increments still apply.
- Saturation: each counter holds at 2^CNT_W-1 and never wraps.
- Snapshot:
  - When snap_req_i=1 and snap_valid_o=0 at an edge, the snap_* fields capture the counter register values present before that edge's increments. snap_valid_o rises the next cycle (1-cycle latency).
  - snap_valid_o and the fields hold stable until an edge with snap_ready_i=1, after which snap_valid_o falls.
  - snap_req_i while snap_valid_o=1 is ignored, including in the acceptance cycle; the requester reasserts.
  - clr_i does not drop a pending snapshot.
- Reset mid-operation clears everything immediately, including a pending snapshot.

Optional Feature:
PERF_OVF_FLAG_EN
- Defined: adds output ovf_o[3:0] (cycle, stall, flush, retire order). Each bit is a sticky flag set the cycle its counter saturates, cleared only by clr_i or reset.
- Undefined: port absent, no flag logic; saturation behaviour unchanged.

Decomposition:
- Shared package perf_pkg:
  - state encoding constants (ST_IDLE, ST_RUN, ST_DONE)
  - counter index constants for the ovf_o bit order
  - default CNT_W
- One natural sub-module, sat_counter: a saturating up-counter with enable, clear and a saturated flag. It is instantiated four times.

Test Plan:
1. Reset, start_i=1 for 10 cycles, no events -> cycle=10, others 0, state RUN.
2. stall_i=1 for 3 cycles, with branch_i=1 in one of them; flush_i=1 for 2 cycles -> stall=2, flush=2.
3. CYCLE_LIMIT=64, start_i held -> state DONE after 64 RUN cycles, cycle=64 frozen, done_o=1. Then clr_i -> all 0, IDLE.
4. snap_req_i at cycle 20 with snap_ready_i=0 for 5 cycles -> snap_valid_o stays high and snap_cycle_o stable at 20. A second request is ignored. snap_ready_i=1 -> valid falls the next cycle.
5. CNT_W=4 with retire_i held for 20 cycles -> retire=15 held. With PERF_OVF_FLAG_EN, ovf_o[3]=1 from the saturating cycle onward.
6. rst_i asserted asynchronously mid-RUN with a snapshot pending -> outputs 0 and state IDLE immediately, without waiting for a clock edge.
